// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | uart_pkg : UART state encoding and line-level constants            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_word_tx_if.sv
// +--------------------------------------------------------------------+
// | uart_word_tx_if : start/word request and serial-line status bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface uart_word_tx_if #(
  parameter int NUM_BYTES = 8
);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic                   transmit;
  logic [8*NUM_BYTES-1:0] tx_word;
  logic                   tx;
  logic                   is_transmitting;
  logic                   tx_done;
  logic [IDX_W-1:0]       byte_index;

  modport master (
    output transmit, tx_word,
    input  tx, is_transmitting, tx_done, byte_index
  );

  modport slave (
    input  transmit, tx_word,
    output tx, is_transmitting, tx_done, byte_index
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +--------------------------------------------------------------------+
// | uart_baud_tick : one-cycle pulse every BIT_CYCLES clocks           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick #(
  parameter int BIT_CYCLES = 434
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  clear,
  output logic tick
);
  localparam int              CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A restart must not see a stale wrap from the free-running idle count.
  assign tick = (cnt_q == LAST) && !clear;

endmodule

`default_nettype wire

// File: rtl/uart_word_tx.sv
// +--------------------------------------------------------------------+
// | uart_word_tx : sends a word as NUM_BYTES UART frames, LSB first    |
// | Option: UART_WORD_TX_PARITY_EN adds an even-parity bit per frame   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_word_tx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 434,
  parameter int NUM_BYTES  = 8
) (
  input  wire           clk,
  input  wire           rst,
  uart_word_tx_if.slave bus
);
  localparam int               WORD_W    = 8 * NUM_BYTES;
  localparam int               IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t       state_q;
  logic [WORD_W-1:0] shift_q;
  logic [2:0]        bit_cnt_q;
  logic [IDX_W-1:0]  byte_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
`ifdef UART_WORD_TX_PARITY_EN
  logic              par_q;
`endif

  logic accept;
  logic tick;

  assign accept = (state_q == IDLE) && bus.transmit;

  uart_baud_tick #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q    <= bus.tx_word;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= START_LEVEL;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
`ifdef UART_WORD_TX_PARITY_EN
            par_q     <= ^shift_q[DATA_BITS-1:0];
`endif
          end
        end
        DATA: begin
          // The whole word shifts once per data bit, so after eight bits
          // the next byte already sits at the bottom of shift_q.
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_WORD_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= STOP_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_q    <= STOP_LEVEL;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_q       <= START_LEVEL;
              state_q    <= START;
            end
          end
        end
        default: begin
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx              = tx_q;
  assign bus.is_transmitting = busy_q;
  assign bus.tx_done         = done_q;
  assign bus.byte_index      = byte_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_tx.sv
// +--------------------------------------------------------------------+
// | tb_uart_word_tx : scoreboard bench for uart_word_tx                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_word_tx;
  localparam int B  = 4;
  localparam int NB = 8;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FB    = FRAME * B;
  localparam int TOTAL = NB * FB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_word_tx_if #(.NUM_BYTES(NB)) bus ();

  uart_word_tx #(
    .BIT_CYCLES (B),
    .NUM_BYTES  (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       line_s[TOTAL];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int j = 0; j < NB; j++) exp_q.push_back(w[8*j +: 8]);
  endtask

  // Runs one word from its accepting edge (i=0) to the tx_done edge (i=TOTAL).
  task automatic send_word(input logic [63:0] w, input int inject_at,
                           input bit hold, input logic [63:0] next_w);
    int bad_busy  = 0;
    int done_seen = 0;
    int unstable  = 0;
    bus.transmit = 1'b1;
    bus.tx_word  = w;
    for (int i = 0; i <= TOTAL; i++) begin
      @(posedge clk); #1;
      if (i < TOTAL) begin
        line_s[i] = bus.tx;
        if (!bus.is_transmitting) bad_busy++;
        if (bus.tx_done) done_seen++;
        if (i % FB == FB / 2) check("byte_index", 64'(bus.byte_index), 64'(i / FB));
      end
      if (i == 0) begin
        check("start_latency", 64'(bus.tx), 64'd0);
        if (!hold) begin
          bus.transmit = 1'b0;
          bus.tx_word  = ~w;
        end
      end
      if (i == inject_at) begin
        bus.transmit = 1'b1;
        bus.tx_word  = 64'hDEAD_BEEF_CAFE_F00D;
      end
      if (i == inject_at + 1 && !hold) bus.transmit = 1'b0;
      if (hold && i == TOTAL - 1) bus.tx_word = next_w;
    end
    check("end_of_word", {58'd0, bus.tx_done, bus.is_transmitting, bus.tx, bus.byte_index},
          64'b101_000);
    check("busy_window", 64'(bad_busy), 64'd0);
    check("early_done", 64'(done_seen), 64'd0);
    for (int i = 0; i < TOTAL; i++)
      if (line_s[i] !== line_s[(i / B) * B + B / 2]) unstable++;
    check("bit_stable", 64'(unstable), 64'd0);
    for (int j = 0; j < NB; j++) begin
      logic [7:0] got;
      logic [7:0] expb;
      int         base;
      base = j * FB;
      for (int k = 0; k < 8; k++) got[k] = line_s[base + (k + 1) * B + B / 2];
      if (exp_q.size() == 0) begin
        check("queue_empty", 64'd1, 64'd0);
        expb = 8'hxx;
      end else begin
        expb = exp_q.pop_front();
      end
      check("data_byte", 64'(got), 64'(expb));
      check("start_bit", 64'(line_s[base + B / 2]), 64'd0);
      check("stop_bit", 64'(line_s[base + (FRAME - 1) * B + B / 2]), 64'd1);
`ifdef UART_WORD_TX_PARITY_EN
      check("parity_bit", 64'(line_s[base + 9 * B + B / 2]), 64'(^expb));
`endif
    end
  endtask

  task automatic idle_window(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if ({bus.tx, bus.is_transmitting, bus.tx_done, bus.byte_index} !== 6'b100_000) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.transmit = 1'b0;
    bus.tx_word  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {58'd0, bus.tx, bus.is_transmitting, bus.tx_done, bus.byte_index},
          64'b100_000);
    rst = 1'b0;
    idle_window("idle_after_reset", 20);

    // Single word, one-cycle request.
    push_word(64'h0123_4567_89AB_CDEF);
    send_word(64'h0123_4567_89AB_CDEF, -1, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("done_single_pulse", {61'd0, bus.tx_done, bus.is_transmitting, bus.tx}, 64'b001);

    // Request while busy must be ignored.
    push_word(64'h0123_4567_89AB_CDEF);
    send_word(64'h0123_4567_89AB_CDEF, 100, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("done_after_ignored", {61'd0, bus.tx_done, bus.is_transmitting, bus.tx}, 64'b001);
    idle_window("no_queued_word", 2 * FB);

    // Asynchronous reset mid-frame.
    bus.transmit = 1'b1;
    bus.tx_word  = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i <= 57; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.transmit = 1'b0;
    end
    check("pre_reset_busy", {62'd0, bus.is_transmitting, bus.byte_index == 3'd1}, 64'b11);
    rst = 1'b1;
    #1;
    check("async_reset", {58'd0, bus.tx, bus.is_transmitting, bus.tx_done, bus.byte_index},
          64'b100_000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_window("idle_after_abort", 3 * FB);

    // Back-to-back words with transmit held high.
    push_word(64'hFFFF_FFFF_0000_0000);
    push_word(64'h0);
    send_word(64'hFFFF_FFFF_0000_0000, -1, 1'b1, 64'h0);
    send_word(64'h0, -1, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("done_second_word", {61'd0, bus.tx_done, bus.is_transmitting, bus.tx}, 64'b001);

    // Byte 0 = 8'h07 exercises an odd data-bit count.
    push_word(64'h0123_4567_89AB_CD07);
    send_word(64'h0123_4567_89AB_CD07, -1, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("done_last_word", {61'd0, bus.tx_done, bus.is_transmitting, bus.tx}, 64'b001);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
